midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI message framer and NUM_VOICES square-wave synth voices.
- Consumes framed 3-byte MIDI messages and assigns each note-on to a voice: a voice already holding that note, else the lowest free voice, else the oldest voice (stolen).
- Routes note-offs and All-Notes-Off to the owning voices.
- Drives a shared note/velocity bus plus a one-hot per-voice load strobe. Each voice latches the bus when its load bit is high.

Parameters:
- NUM_VOICES, 4, number of voices managed (2..8).
- CHANNEL, 0, MIDI channel (0..15) accepted; messages on other channels are ignored.
- AGE_W, 8, width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock.
- resetq  in  1  synchronous, active-high reset.
- message_received  in  1  one-cycle pulse; command/value1/value2 are valid in that cycle.
- command  in  8  MIDI status byte.
- value1  in  8  note number / controller number.
- value2  in  8  velocity / controller value.
- voice_load  out  NUM_VOICES  one-hot, one-cycle strobe selecting the voice that latches the bus.
- voice_note  out  8  note number for the loaded voice.
- voice_velocity  out  8  velocity for the loaded voice; 0 means release.
- voice_active  out  NUM_VOICES  bit i high while voice i holds a note.
- busy  out  1  high while a message is being processed.
- drop  out  1  one-cycle pulse when a message is discarded because the pending buffer is full.

Behaviour:
- Reset: every output is 0. All voices are free with age 0 and held note 0. The pending buffer is empty. State is IDLE. Reset applies immediately mid-operation, and no further strobe is issued.
- Decoding. The channel must satisfy command[3:0]==CHANNEL.
  - NOTE_ON: command[7:4]==9 and value2!=0.
  - NOTE_OFF: command[7:4]==8, or command[7:4]==9 with value2==0.
  - ALL_OFF: command[7:4]==B and value1==123.
  - Anything else, or a message with value1[7] set, is ignored: busy stays 0 and there is no strobe.
- Acceptance:
  - A message in IDLE is accepted in its pulse cycle.
  - A message arriving while busy is stored in the 1-entry pending buffer.
  - A message arriving while busy with the buffer full is discarded and drop pulses for one cycle.
  - A buffered message is accepted in the cycle after the current operation ends, so busy stays high continuously.
- States: IDLE -> SCAN -> LOAD -> IDLE; ALL_OFF is a separate path from IDLE.
- SCAN lasts NUM_VOICES cycles and examines voice i in scan cycle i. It records:
  - the first match, meaning an active voice whose held note == value1;
  - the lowest free voice;
  - the oldest active voice: maximum age, ties broken by lowest index.
- LOAD is one cycle, with outputs registered. voice_load, voice_note and voice_velocity are valid in the cycle NUM_VOICES+2 cycles after the accepted pulse. busy is high from the cycle after acceptance through that strobe cycle inclusive.
- NOTE_ON target selection: match, else free voice, else oldest voice.
  - The target gets held note = value1 and its voice_active bit sets.
  - The target's age resets to 0. Every other active voice increments its age, saturating at 2^AGE_W-1.
  - The bus carries value1 and value2.
- NOTE_OFF with a match:
  - Strobe the matched voice with voice_velocity=0 and voice_note=value1.
  - Clear that voice's active bit and set its age to 0.
- NOTE_OFF with no match: SCAN runs, no strobe is issued, and busy drops after the LOAD cycle (same timing).
- ALL_OFF:
  - One cycle per voice, i = 0..NUM_VOICES-1. Each active voice is strobed with velocity 0 and its held note; inactive voices are skipped with no strobe.
  - Afterwards all voices are free.
  - busy lasts NUM_VOICES+1 cycles after acceptance.
- At most one voice_load bit is high in any cycle.
- The bus holds its last value when no strobe is issued.
- voice_active updates in the same cycle as the corresponding strobe.

Test Plan:
1. After reset: note-on 0x90/60/100 -> voice_load=0001 exactly 6 cycles after the pulse, with voice_note=60, voice_velocity=100, voice_active=0001 and busy high for cycles 1..6.
2. Fill voices with notes 60,62,64,67. Then note-on 0x90/72/80 -> voice 0 (oldest) is stolen, voice_load=0001, voice_note=72, voice_active=1111.
3. Hold notes 60 and 62 on voices 0 and 1:
   - 0x80/60/0 -> voice_load=0001, velocity 0, voice_active=0010.
   - Then 0x90/62/0 -> voice_load=0010, voice_active=0000.
   - Then 0x80/50/0 -> no strobe, and busy pulses for 6 cycles.
4. Three note-ons on consecutive cycles:
   - The first is processed and the second is buffered; the third produces drop=1 for one cycle.
   - Strobes occur at cycle 6 (first message) and cycle 12 (second message); busy never deasserts between them.
5. Three voices active, then 0xB0/123/0 -> strobes on voices 0, 1, 2 in consecutive cycles with velocity 0, no strobe for voice 3, and voice_active=0000. A 0x91 note-on (channel 1) is ignored.
6. Assert resetq during SCAN -> no strobe afterwards, every output is 0 in the next cycle, and the next note-on allocates voice 0.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Polyphonic voice scheduler sitting between the MIDI message framer and
//   NUM_VOICES synth voices. Each accepted note-on is given to the voice that
//   already holds the note, else the lowest free voice, else the oldest voice.
//   Note-offs release the owning voice and All-Notes-Off releases every voice.
//
// Ports:
//   clk              system clock
//   resetq           synchronous, active-high reset
//   message_received one-cycle pulse qualifying command/value1/value2
//   command          MIDI status byte
//   value1           note / controller number
//   value2           velocity / controller value
//   voice_load       one-hot, one-cycle strobe for the voice latching the bus
//   voice_note       note number on the shared bus
//   voice_velocity   velocity on the shared bus (0 = release)
//   voice_active     bit i high while voice i holds a note
//   busy             high while a message is being processed
//   drop             one-cycle pulse when a message is lost (buffer full)
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter int AGE_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  message_received,
  input  logic [7:0]            command,
  input  logic [7:0]            value1,
  input  logic [7:0]            value2,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [7:0]            voice_note,
  output logic [7:0]            voice_velocity,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  busy,
  output logic                  drop
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0]    LAST    = IW'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, LOAD, ALLOFF} state_t;
  typedef enum logic [1:0] {K_NONE, K_ON, K_OFF, K_ALL} kind_t;

  state_t state, state_next;
  kind_t  in_kind, start_kind, cur_kind, pend_kind;

  logic       pend_valid;
  logic [7:0] pend_note, pend_vel, cur_note, cur_vel, start_note, start_vel;
  logic       take_pend, take_new, start, store_new, drop_new;

  logic [IW-1:0]    scan_idx;
  logic             match_found, free_found, old_found;
  logic [IW-1:0]    match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  logic [7:0]       held_note [NUM_VOICES];
  logic [AGE_W-1:0] age       [NUM_VOICES];

  logic          strobe_en;
  logic [IW-1:0] strobe_idx;
  logic [7:0]    strobe_note, strobe_vel;

  // Classify the incoming message; a note-on with velocity 0 is a release.
  always_comb begin
    in_kind = K_NONE;
    if (message_received && command[3:0] == 4'(CHANNEL) && !value1[7]) begin
      if (command[7:4] == 4'h9 && value2 != 8'd0)
        in_kind = K_ON;
      else if (command[7:4] == 4'h8 || command[7:4] == 4'h9)
        in_kind = K_OFF;
      else if (command[7:4] == 4'hB && value1 == 8'd123)
        in_kind = K_ALL;
    end
  end

  // A buffered message always wins the idle slot; a message arriving in that
  // same cycle refills the buffer that is being emptied.
  always_comb begin
    take_pend  = (state == IDLE) && pend_valid;
    take_new   = (state == IDLE) && !pend_valid && (in_kind != K_NONE);
    start      = take_pend || take_new;
    start_kind = take_pend ? pend_kind : in_kind;
    start_note = take_pend ? pend_note : value1;
    start_vel  = take_pend ? pend_vel  : value2;
    store_new  = (in_kind != K_NONE) && !take_new && (!pend_valid || take_pend);
    drop_new   = (in_kind != K_NONE) && !take_new && pend_valid && !take_pend;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (resetq)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: SCAN and ALLOFF each walk every voice once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (start_kind == K_ALL) ? ALLOFF : SCAN;
      SCAN:    if (scan_idx == LAST) state_next = LOAD;
      LOAD:    state_next = IDLE;
      ALLOFF:  if (scan_idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe decision. Stealing needs no guard: with no free voice every voice
  // is active, so the oldest-voice record is always valid.
  always_comb begin
    strobe_en   = 1'b0;
    strobe_idx  = '0;
    strobe_note = voice_note;
    strobe_vel  = voice_velocity;
    case (state)
      LOAD: begin
        if (cur_kind == K_ON) begin
          strobe_en   = 1'b1;
          strobe_idx  = match_found ? match_idx : (free_found ? free_idx : old_idx);
          strobe_note = cur_note;
          strobe_vel  = cur_vel;
        end else if (cur_kind == K_OFF && match_found) begin
          strobe_en   = 1'b1;
          strobe_idx  = match_idx;
          strobe_note = cur_note;
          strobe_vel  = 8'd0;
        end
      end
      ALLOFF: begin
        if (voice_active[scan_idx]) begin
          strobe_en   = 1'b1;
          strobe_idx  = scan_idx;
          strobe_note = held_note[scan_idx];
          strobe_vel  = 8'd0;
        end
      end
      default: ;
    endcase
  end

  // Datapath: pending buffer, scan records, per-voice state and the
  // registered bus outputs.
  always_ff @(posedge clk) begin
    if (resetq) begin
      voice_load     <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_active   <= '0;
      busy           <= 1'b0;
      drop           <= 1'b0;
      pend_valid     <= 1'b0;
      pend_kind      <= K_NONE;
      pend_note      <= '0;
      pend_vel       <= '0;
      cur_kind       <= K_NONE;
      cur_note       <= '0;
      cur_vel        <= '0;
      scan_idx       <= '0;
      match_found    <= 1'b0;
      free_found     <= 1'b0;
      old_found      <= 1'b0;
      match_idx      <= '0;
      free_idx       <= '0;
      old_idx        <= '0;
      old_age        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        held_note[i] <= '0;
        age[i]       <= '0;
      end
    end else begin
      // busy also covers the strobe cycle, when the FSM is already back in IDLE.
      busy <= (state_next != IDLE) || (state == LOAD) || (state == ALLOFF);
      drop <= drop_new;

      voice_load <= '0;
      if (strobe_en) begin
        voice_load     <= NUM_VOICES'(1) << strobe_idx;
        voice_note     <= strobe_note;
        voice_velocity <= strobe_vel;
      end

      if (take_pend)
        pend_valid <= 1'b0;
      if (store_new) begin
        pend_valid <= 1'b1;
        pend_kind  <= in_kind;
        pend_note  <= value1;
        pend_vel   <= value2;
      end

      if (start) begin
        cur_kind    <= start_kind;
        cur_note    <= start_note;
        cur_vel     <= start_vel;
        scan_idx    <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        old_found   <= 1'b0;
      end

      case (state)
        SCAN: begin
          if (voice_active[scan_idx] && held_note[scan_idx] == cur_note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!voice_active[scan_idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          // Strict greater-than keeps the lowest index on equal ages.
          if (voice_active[scan_idx] && (!old_found || age[scan_idx] > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= age[scan_idx];
          end
          scan_idx <= scan_idx + IW'(1);
        end
        LOAD: begin
          if (strobe_en && cur_kind == K_ON) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IW'(i) == strobe_idx) begin
                held_note[i]    <= cur_note;
                age[i]          <= '0;
                voice_active[i] <= 1'b1;
              end else if (voice_active[i] && age[i] != AGE_MAX) begin
                age[i] <= age[i] + AGE_W'(1);
              end
            end
          end else if (strobe_en) begin
            voice_active[strobe_idx] <= 1'b0;
            age[strobe_idx]          <= '0;
          end
        end
        ALLOFF: begin
          voice_active[scan_idx] <= 1'b0;
          age[scan_idx]          <= '0;
          scan_idx               <= scan_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
module tb_midi_voice_allocator;

  localparam int NV   = 4;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          resetq = 1'b1;
  logic          message_received = 1'b0;
  logic [7:0]    command = '0;
  logic [7:0]    value1 = '0;
  logic [7:0]    value2 = '0;
  logic [NV-1:0] voice_load;
  logic [7:0]    voice_note;
  logic [7:0]    voice_velocity;
  logic [NV-1:0] voice_active;
  logic          busy;
  logic          drop;

  midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(0), .AGE_W(8)) dut (
    .clk(clk),
    .resetq(resetq),
    .message_received(message_received),
    .command(command),
    .value1(value1),
    .value2(value2),
    .voice_load(voice_load),
    .voice_note(voice_note),
    .voice_velocity(voice_velocity),
    .voice_active(voice_active),
    .busy(busy),
    .drop(drop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Expected-output timeline, indexed by absolute cycle number.
  bit [NV-1:0] exp_load [MAXC];
  bit [NV-1:0] exp_set  [MAXC];
  bit [NV-1:0] exp_clr  [MAXC];
  bit [7:0]    exp_note [MAXC];
  bit [7:0]    exp_vel  [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_drop [MAXC];
  bit          rst_mark [MAXC];

  // Abstract voice state: what each voice holds, independent of timing.
  bit m_active [NV];
  int m_note   [NV];
  int m_age    [NV];
  int busy_until = -1;
  bit have_wait = 1'b0;
  int w_kind, w_note, w_vel;

  bit [NV-1:0] e_act = '0;
  bit [7:0]    e_note = '0;
  bit [7:0]    e_vel = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // 0 ignored, 1 note-on, 2 note-off, 3 all-notes-off
  function automatic int decode(input logic [7:0] cmd, input logic [7:0] v1, input logic [7:0] v2);
    int hi;
    hi = int'(cmd) / 16;
    if (int'(cmd) % 16 != 0 || v1 >= 8'd128) return 0;
    if (hi == 9 && v2 != 0) return 1;
    if (hi == 8 || hi == 9) return 2;
    if (hi == 11 && v1 == 8'd123) return 3;
    return 0;
  endfunction

  function automatic void accept(input int t, input int k, input int n, input int v);
    int s, match, tg;
    if (k == 3) begin
      for (int c = t + 1; c <= t + NV + 1; c++) exp_busy[c] = 1'b1;
      for (int i = 0; i < NV; i++) begin
        if (m_active[i]) begin
          s = t + 2 + i;
          exp_load[s]    = NV'(1) << i;
          exp_note[s]    = 8'(m_note[i]);
          exp_vel[s]     = 8'd0;
          exp_clr[s][i]  = 1'b1;
        end
        m_active[i] = 1'b0;
        m_age[i]    = 0;
      end
      busy_until = t + NV + 1;
    end else begin
      s = t + NV + 2;
      for (int c = t + 1; c <= s; c++) exp_busy[c] = 1'b1;
      busy_until = s;
      match = -1;
      for (int i = 0; i < NV; i++)
        if (m_active[i] && m_note[i] == n && match < 0) match = i;
      if (k == 1) begin
        tg = match;
        if (tg < 0)
          for (int i = 0; i < NV; i++) if (!m_active[i] && tg < 0) tg = i;
        if (tg < 0) begin
          tg = 0;
          for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tg]) tg = i;
        end
        for (int i = 0; i < NV; i++)
          if (i != tg && m_active[i]) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
        m_age[tg]    = 0;
        m_note[tg]   = n;
        m_active[tg] = 1'b1;
        exp_load[s]    = NV'(1) << tg;
        exp_note[s]    = 8'(n);
        exp_vel[s]     = 8'(v);
        exp_set[s][tg] = 1'b1;
      end else if (match >= 0) begin
        m_active[match] = 1'b0;
        m_age[match]    = 0;
        exp_load[s]       = NV'(1) << match;
        exp_note[s]       = 8'(n);
        exp_vel[s]        = 8'd0;
        exp_clr[s][match] = 1'b1;
      end
    end
  endfunction

  // Called once per cycle with whatever the framer presents in that cycle.
  function automatic void modelMsg(input int t, input logic valid, input logic [7:0] cmd,
                                   input logic [7:0] v1, input logic [7:0] v2);
    int k;
    k = valid ? decode(cmd, v1, v2) : 0;
    if (have_wait && t >= busy_until) begin
      have_wait = 1'b0;
      accept(t, w_kind, w_note, w_vel);
    end
    if (k != 0) begin
      if (t >= busy_until) begin
        accept(t, k, int'(v1), int'(v2));
      end else if (!have_wait) begin
        have_wait = 1'b1;
        w_kind = k;
        w_note = int'(v1);
        w_vel  = int'(v2);
      end else begin
        exp_drop[t + 1] = 1'b1;
      end
    end
  endfunction

  function automatic void modelReset(input int t);
    for (int c = t + 1; c <= t + 10; c++) begin
      exp_load[c] = '0;
      exp_set[c]  = '0;
      exp_clr[c]  = '0;
      exp_note[c] = '0;
      exp_vel[c]  = '0;
      exp_busy[c] = 1'b0;
      exp_drop[c] = 1'b0;
    end
    rst_mark[t + 1] = 1'b1;
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = 0;
      m_age[i]    = 0;
    end
    busy_until = -1;
    have_wait  = 1'b0;
  endfunction

  // Every-cycle comparison against the model timeline, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (rst_mark[cyc]) begin
        e_act  = '0;
        e_note = '0;
        e_vel  = '0;
      end
      e_act = (e_act | exp_set[cyc]) & ~exp_clr[cyc];
      if (exp_load[cyc] != '0) begin
        e_note = exp_note[cyc];
        e_vel  = exp_vel[cyc];
      end
      if (check_en) begin
        checkOutput("voice_load", voice_load, exp_load[cyc]);
        checkOutput("voice_note", voice_note, e_note);
        checkOutput("voice_velocity", voice_velocity, e_vel);
        checkOutput("voice_active", voice_active, e_act);
        checkOutput("busy", busy, exp_busy[cyc]);
        checkOutput("drop", drop, exp_drop[cyc]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] cmd, input logic [7:0] v1, input logic [7:0] v2);
    step();
    message_received = v;
    command = cmd;
    value1  = v1;
    value2  = v2;
    modelMsg(cyc, v, cmd, v1, v2);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    step();
    message_received = 1'b0;
    resetq = 1'b1;
    modelReset(cyc);
    step();
    resetq = 1'b0;
    modelMsg(cyc, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] c, n, v;
    int r;

    doReset();
    check_en = 1'b1;

    // Single note-on: strobe six cycles after the pulse, busy on cycles 1..6.
    applyStimulus(1'b1, 8'h90, 8'd60, 8'd100);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      checkOutput("t1_busy", busy, 1);
    end
    checkOutput("t1_load", voice_load, 4'b0001);
    checkOutput("t1_note", voice_note, 8'd60);
    checkOutput("t1_vel", voice_velocity, 8'd100);
    checkOutput("t1_active", voice_active, 4'b0001);
    idle(1);
    checkOutput("t1_busy_end", busy, 0);

    // Fill all voices, then steal the oldest.
    applyStimulus(1'b1, 8'h90, 8'd62, 8'd100); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd64, 8'd100); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd67, 8'd100); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd72, 8'd80);  idle(6);
    checkOutput("t2_load", voice_load, 4'b0001);
    checkOutput("t2_note", voice_note, 8'd72);
    checkOutput("t2_active", voice_active, 4'b1111);
    idle(2);

    // Note-off routing, velocity-0 note-on, and an unmatched note-off.
    doReset();
    applyStimulus(1'b1, 8'h90, 8'd60, 8'd90); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd62, 8'd90); idle(7);
    applyStimulus(1'b1, 8'h80, 8'd60, 8'd0);  idle(6);
    checkOutput("t3_off_load", voice_load, 4'b0001);
    checkOutput("t3_off_vel", voice_velocity, 8'd0);
    checkOutput("t3_off_active", voice_active, 4'b0010);
    idle(1);
    applyStimulus(1'b1, 8'h90, 8'd62, 8'd0);  idle(6);
    checkOutput("t3_v0_load", voice_load, 4'b0010);
    checkOutput("t3_v0_active", voice_active, 4'b0000);
    idle(1);
    applyStimulus(1'b1, 8'h80, 8'd50, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      checkOutput("t3_nomatch_busy", busy, 1);
      checkOutput("t3_nomatch_load", voice_load, 0);
    end
    idle(1);
    checkOutput("t3_nomatch_idle", busy, 0);

    // Back-to-back note-ons: one processed, one buffered, one dropped.
    doReset();
    applyStimulus(1'b1, 8'h90, 8'd60, 8'd90);
    applyStimulus(1'b1, 8'h90, 8'd62, 8'd90);
    applyStimulus(1'b1, 8'h90, 8'd64, 8'd90);
    for (int k = 3; k <= 12; k++) begin
      idle(1);
      checkOutput("t4_busy", busy, 1);
      if (k == 3) checkOutput("t4_drop", drop, 1);
      if (k == 6) checkOutput("t4_load_first", voice_load, 4'b0001);
      if (k == 12) checkOutput("t4_load_second", voice_load, 4'b0010);
    end
    idle(2);

    // All-notes-off with three active voices, then an off-channel note-on.
    doReset();
    applyStimulus(1'b1, 8'h90, 8'd60, 8'd90); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd62, 8'd90); idle(7);
    applyStimulus(1'b1, 8'h90, 8'd64, 8'd90); idle(7);
    applyStimulus(1'b1, 8'hB0, 8'd123, 8'd0);
    idle(1); checkOutput("t5_load_c1", voice_load, 4'b0000);
    idle(1); checkOutput("t5_load_c2", voice_load, 4'b0001);
    idle(1); checkOutput("t5_load_c3", voice_load, 4'b0010);
    idle(1); checkOutput("t5_load_c4", voice_load, 4'b0100);
    checkOutput("t5_vel", voice_velocity, 8'd0);
    idle(1); checkOutput("t5_load_c5", voice_load, 4'b0000);
    checkOutput("t5_active", voice_active, 4'b0000);
    applyStimulus(1'b1, 8'h91, 8'd70, 8'd100);
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      checkOutput("t5_ch1_busy", busy, 0);
      checkOutput("t5_ch1_load", voice_load, 0);
    end

    // Reset while scanning.
    doReset();
    applyStimulus(1'b1, 8'h90, 8'd60, 8'd100);
    idle(1);
    doReset();
    checkOutput("t6_load", voice_load, 0);
    checkOutput("t6_note", voice_note, 0);
    checkOutput("t6_vel", voice_velocity, 0);
    checkOutput("t6_active", voice_active, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_drop", drop, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      checkOutput("t6_no_strobe", voice_load, 0);
    end
    applyStimulus(1'b1, 8'h90, 8'd65, 8'd100); idle(6);
    checkOutput("t6_realloc_load", voice_load, 4'b0001);
    checkOutput("t6_realloc_note", voice_note, 8'd65);

    // Randomized traffic against the model.
    for (int it = 0; it < 600 && cyc < MAXC - 200; it++) begin
      r = $urandom_range(0, 99);
      n = 8'(60 + $urandom_range(0, 7));
      v = 8'($urandom_range(1, 127));
      if (r < 50)      begin c = 8'h90; end
      else if (r < 68) begin c = 8'h80; v = 8'($urandom_range(0, 127)); end
      else if (r < 73) begin c = 8'h90; v = 8'd0; end
      else if (r < 76) begin c = 8'hB0; n = 8'd123; v = 8'd0; end
      else if (r < 83) begin c = 8'h90 | 8'($urandom_range(1, 15)); end
      else if (r < 88) begin c = 8'h90; n = n | 8'h80; end
      else if (r < 98) begin
        c = (r < 93) ? 8'hA0 : 8'hB0;
        n = 8'($urandom_range(0, 122));
      end
      else begin c = 8'h00; end
      if (c == 8'h00)
        doReset();
      else
        applyStimulus(1'b1, c, n, v);
      if ($urandom_range(0, 3) != 0) idle($urandom_range(0, 9));
    end

    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
